ahb_resp_mux: RTL and testbench

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

---
 rtl/cvw.sv | 19 +
 rtl/ahb_default_sub.sv | 165 ++++++++++++++++
 rtl/ahb_resp_mux.sv | 111 +++++++++++
 tb/tb_ahb_resp_mux.sv | 565 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvw.sv
// Shared package: default-subordinate state encoding and error-cause codes
// used by the AHB-Lite response multiplexer and its default subordinate.
package cvw;

    // Default-subordinate states. OKAY passes the bus through, while ERR1
    // and ERR2 form the two-cycle ERROR response.
    typedef enum logic [1:0] {
        DS_OKAY = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } defSubStateT;

    // ErrCause bit patterns. A value of 2'b11 means both an unmapped access
    // and a timeout have been seen since the last clear.
    localparam logic [1:0] ERR_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] ERR_CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_CAUSE_TIMEOUT  = 2'b10;

endpackage

// File: rtl/ahb_default_sub.sv
// Default subordinate. It answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR response, watches for subordinates that stall the bus too
// long, and keeps a sticky record of the first error address and the causes.
module ahb_default_sub #(
    parameter int AW  = 34,
    parameter int TOW = 8
) (
    input  logic          hclk_i,
    input  logic          reset_i,
    input  logic          hready_i,
    input  logic          noneNext_i,
    input  logic [AW-1:0] haddr_i,
    input  logic          stalled_i,
    input  logic          errClear_i,
    output logic          hready_o,
    output logic          hresp_o,
    output logic          errIntr_o,
    output logic [1:0]    errCause_o,
    output logic [AW-1:0] errAddr_o
);
    import cvw::*;

    localparam logic [TOW-1:0] TO_MAX  = '1;
    localparam logic [TOW-1:0] TO_LAST = TO_MAX - 1'b1;

    defSubStateT    state_q;
    logic           hready_q;
    logic           hresp_q;
    logic [AW-1:0]  shadowAddr_q;
    logic [AW-1:0]  shadowAddr_d;
    logic [TOW-1:0] toCount_q;
    logic [TOW-1:0] toCount_d;
    logic           errIntr_q;
    logic           errIntr_d;
    logic [1:0]     errCause_q;
    logic [1:0]     errCause_d;
    logic [AW-1:0]  errAddr_q;
    logic [AW-1:0]  errAddr_d;
    logic           unmappedHit;
    logic           timeoutHit;

    // An unmapped transfer is only accepted when the address phase completes.
    assign unmappedHit = hready_i & noneNext_i;

    // The timeout fires once, on the edge where the stall counter would
    // reach all-ones; saturation keeps it from firing again.
    assign timeoutHit = stalled_i & (toCount_q == TO_LAST);

    // Error-response FSM; the bus outputs are registered alongside the state
    // so ERR1 presents a wait state with ERROR and ERR2 completes it.
    always_ff @(posedge hclk_i) begin
        if (reset_i) begin
            state_q  <= DS_OKAY;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            case (state_q)
                DS_OKAY: begin
                    if (unmappedHit) begin
                        state_q  <= DS_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else begin
                        state_q  <= DS_OKAY;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                DS_ERR1: begin
                    state_q  <= DS_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                DS_ERR2: begin
                    if (unmappedHit) begin
                        state_q  <= DS_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= 1'b1;
                    end else begin
                        state_q  <= DS_OKAY;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= DS_OKAY;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow address follows HADDR whenever an address phase is accepted.
    always_comb begin
        shadowAddr_d = shadowAddr_q;
        if (hready_i) begin
            shadowAddr_d = haddr_i;
        end
    end

    // Stall counter: counts wait states of a selected subordinate, clears on
    // any completed cycle and saturates at all-ones.
    always_comb begin
        toCount_d = toCount_q;
        if (hready_i) begin
            toCount_d = '0;
        end else if (stalled_i && (toCount_q != TO_MAX)) begin
            toCount_d = toCount_q + 1'b1;
        end
    end

    // Sticky error capture. The clear is applied first so an error arriving
    // in the same cycle survives and records its own address. The unmapped
    // capture uses the shadow value being loaded on this edge, which is the
    // address of the transfer that is entering ERR1.
    always_comb begin
        errIntr_d  = errIntr_q;
        errCause_d = errCause_q;
        errAddr_d  = errAddr_q;
        if (errClear_i) begin
            errIntr_d  = 1'b0;
            errCause_d = ERR_CAUSE_NONE;
            errAddr_d  = '0;
        end
        if (unmappedHit) begin
            if (!errIntr_d) begin
                errAddr_d = shadowAddr_d;
            end
            errIntr_d  = 1'b1;
            errCause_d = errCause_d | ERR_CAUSE_UNMAPPED;
        end
        if (timeoutHit) begin
            if (!errIntr_d) begin
                errAddr_d = shadowAddr_q;
            end
            errIntr_d  = 1'b1;
            errCause_d = errCause_d | ERR_CAUSE_TIMEOUT;
        end
    end

    // Register the shadow address, stall counter and error record.
    always_ff @(posedge hclk_i) begin
        if (reset_i) begin
            shadowAddr_q <= '0;
            toCount_q    <= '0;
            errIntr_q    <= 1'b0;
            errCause_q   <= ERR_CAUSE_NONE;
            errAddr_q    <= '0;
        end else begin
            shadowAddr_q <= shadowAddr_d;
            toCount_q    <= toCount_d;
            errIntr_q    <= errIntr_d;
            errCause_q   <= errCause_d;
            errAddr_q    <= errAddr_d;
        end
    end

    assign hready_o   = hready_q;
    assign hresp_o    = hresp_q;
    assign errIntr_o  = errIntr_q;
    assign errCause_o = errCause_q;
    assign errAddr_o  = errAddr_q;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer. It tracks which subordinate owns the data
// phase and steers that subordinate's response back to the manager, and it
// falls back to the default subordinate for idle or unmapped transfers.
module ahb_resp_mux #(
    parameter int NS  = 8,
    parameter int DW  = 64,
    parameter int AW  = 34,
    parameter int TOW = 8
) (
    input  logic             HCLK,
    input  logic             reset,
    input  logic [AW-1:0]    HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [NS-1:0]    HSEL,
    input  logic [NS*DW-1:0] HRDATAS,
    input  logic [NS-1:0]    HREADYOUTS,
    input  logic [NS-1:0]    HRESPS,
    output logic [DW-1:0]    HRDATA,
    output logic             HREADY,
    output logic             HRESP,
    output logic [NS-1:0]    HSELD,
    output logic             ErrIntr,
    output logic [AW-1:0]    ErrAddr,
    output logic [1:0]       ErrCause,
    input  logic             ErrClear
);

    logic [NS-1:0] hselData_q;
    logic          noneData_q;
    logic          noneData_d;
    logic          defReady;
    logic          defResp;
    logic          stalled;
    logic [DW-1:0] muxData;
    logic          muxReady;
    logic          muxResp;
    logic          unusedTransBit;

    // HTRANS[0] only separates NONSEQ from SEQ and IDLE from BUSY; neither
    // distinction matters to the response path.
    assign unusedTransBit = HTRANS[0];

    // Unmapped active transfer: no select with NONSEQ or SEQ.
    assign noneData_d = (HSEL == '0) & HTRANS[1];

    // Data-phase ownership advances only when the previous transfer completes.
    always_ff @(posedge HCLK) begin
        if (reset) begin
            hselData_q <= '0;
            noneData_q <= 1'b0;
        end else if (HREADY) begin
            hselData_q <= HSEL;
            noneData_q <= noneData_d;
        end
    end

    // AND-OR mux over the data-phase selects; with a legal one-hot select it
    // picks a single subordinate, with an illegal multi-hot select it ORs them.
    always_comb begin
        muxData  = '0;
        muxReady = 1'b0;
        muxResp  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (hselData_q[i]) begin
                muxData  = muxData | HRDATAS[i*DW +: DW];
                muxReady = muxReady | HREADYOUTS[i];
                muxResp  = muxResp | HRESPS[i];
            end
        end
    end

    // Final response choice: a selected subordinate, the default subordinate
    // for an unmapped transfer, or an immediate OKAY for IDLE/BUSY.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (hselData_q != '0) begin
            HRDATA = muxData;
            HREADY = muxReady;
            HRESP  = muxResp;
        end else if (noneData_q) begin
            HREADY = defReady;
            HRESP  = defResp;
        end
    end

    // A selected subordinate holding the bus in a wait state.
    assign stalled = (hselData_q != '0) & ~HREADY;

    ahb_default_sub #(
        .AW  (AW),
        .TOW (TOW)
    ) u_default_sub (
        .hclk_i     (HCLK),
        .reset_i    (reset),
        .hready_i   (HREADY),
        .noneNext_i (noneData_d),
        .haddr_i    (HADDR),
        .stalled_i  (stalled),
        .errClear_i (ErrClear),
        .hready_o   (defReady),
        .hresp_o    (defResp),
        .errIntr_o  (ErrIntr),
        .errCause_o (ErrCause),
        .errAddr_o  (ErrAddr)
    );

    assign HSELD = hselData_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Testbench for ahb_resp_mux: directed scenarios plus a randomized run
// checked against a transaction-level model of the response rules.
module tb_ahb_resp_mux;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int AW  = 34;
    localparam int TOW = 8;
    localparam int MAX_STALL = (1 << TOW) - 1;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic             HCLK = 1'b0;
    logic             reset;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic [NS-1:0]    HSEL;
    logic [NS*DW-1:0] HRDATAS;
    logic [NS-1:0]    HREADYOUTS;
    logic [NS-1:0]    HRESPS;
    logic [DW-1:0]    HRDATA;
    logic             HREADY;
    logic             HRESP;
    logic [NS-1:0]    HSELD;
    logic             ErrIntr;
    logic [AW-1:0]    ErrAddr;
    logic [1:0]       ErrCause;
    logic             ErrClear;

    int compareCount  = 0;
    int mismatchCount = 0;

    ahb_resp_mux #(
        .NS  (NS),
        .DW  (DW),
        .AW  (AW),
        .TOW (TOW)
    ) dut (
        .HCLK       (HCLK),
        .reset      (reset),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSEL       (HSEL),
        .HRDATAS    (HRDATAS),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HSELD      (HSELD),
        .ErrIntr    (ErrIntr),
        .ErrAddr    (ErrAddr),
        .ErrCause   (ErrCause),
        .ErrClear   (ErrClear)
    );

    always #5 HCLK = ~HCLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [NS-1:0] sel, input logic [1:0] trans,
                                 input logic [AW-1:0] addr);
        HSEL   = sel;
        HTRANS = trans;
        HADDR  = addr;
    endtask

    task automatic setSub(input int idx, input logic [DW-1:0] data, input logic rdy,
                          input logic resp);
        HRDATAS[idx*DW +: DW] = data;
        HREADYOUTS[idx]       = rdy;
        HRESPS[idx]           = resp;
    endtask

    task automatic idleBus();
        applyStimulus('0, TR_IDLE, '0);
        HRDATAS    = '0;
        HREADYOUTS = '1;
        HRESPS     = '0;
        ErrClear   = 1'b0;
    endtask

    task automatic pulseClear();
        ErrClear = 1'b1;
        step();
        ErrClear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleBus();
        HRDATAS = {NS{32'hA5A5_5A5A}};
        step();
        step();
        reset = 1'b0;
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL reset_ready_resp: got %b expected 10", {HREADY, HRESP});
        end
        compareCount++;
        if (HRDATA !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_hrdata: got %0h expected 0", HRDATA);
        end
        compareCount++;
        if (HSELD !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_hseld: got %b expected 0000", HSELD);
        end
        compareCount++;
        if ({ErrIntr, ErrCause} !== 3'b000 || ErrAddr !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_err: got intr=%b cause=%b addr=%0h expected 0/00/0",
                     ErrIntr, ErrCause, ErrAddr);
        end
        idleBus();
        step();
    endtask

    task automatic test_mapped_read();
        idleBus();
        applyStimulus(4'b0100, TR_NONSEQ, 34'h2000);
        step();
        applyStimulus('0, TR_IDLE, '0);
        setSub(0, 32'h1111_1111, 1'b1, 1'b1);
        setSub(1, 32'h5555_5555, 1'b0, 1'b1);
        setSub(2, 32'hDEAD_BEEF, 1'b1, 1'b0);
        setSub(3, 32'h7777_7777, 1'b0, 1'b1);
        #2;
        compareCount++;
        if (HRDATA !== 32'hDEAD_BEEF) begin
            mismatchCount++;
            $display("[TB] FAIL mapped_hrdata: got %0h expected deadbeef", HRDATA);
        end
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL mapped_ready_resp: got %b expected 10", {HREADY, HRESP});
        end
        compareCount++;
        if (HSELD !== 4'b0100) begin
            mismatchCount++;
            $display("[TB] FAIL mapped_hseld: got %b expected 0100", HSELD);
        end
        step();
        idleBus();
        applyStimulus(4'b1000, TR_SEQ, 34'h2004);
        step();
        applyStimulus('0, TR_IDLE, '0);
        setSub(3, 32'hCAFE_F00D, 1'b0, 1'b0);
        setSub(2, 32'h0BAD_CAFE, 1'b1, 1'b1);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b00 || HSELD !== 4'b1000) begin
            mismatchCount++;
            $display("[TB] FAIL mapped_wait: got rdy/resp=%b hseld=%b expected 00 1000",
                     {HREADY, HRESP}, HSELD);
        end
        step();
        setSub(3, 32'hCAFE_F00D, 1'b1, 1'b1);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b11 || HRDATA !== 32'hCAFE_F00D) begin
            mismatchCount++;
            $display("[TB] FAIL mapped_error_pass: got rdy/resp=%b data=%0h expected 11 cafef00d",
                     {HREADY, HRESP}, HRDATA);
        end
        step();
        idleBus();
        step();
    endtask

    task automatic test_unmapped_error();
        idleBus();
        pulseClear();
        applyStimulus('0, TR_NONSEQ, 34'h1234);
        step();
        applyStimulus('0, TR_IDLE, '0);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b01 || HRDATA !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL unmapped_err1: got rdy/resp=%b data=%0h expected 01 0",
                     {HREADY, HRESP}, HRDATA);
        end
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b11) begin
            mismatchCount++;
            $display("[TB] FAIL unmapped_err2: got %b expected 11", {HREADY, HRESP});
        end
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL unmapped_back_okay: got %b expected 10", {HREADY, HRESP});
        end
        compareCount++;
        if (ErrIntr !== 1'b1 || ErrCause !== 2'b01 || ErrAddr !== 34'h1234) begin
            mismatchCount++;
            $display("[TB] FAIL unmapped_capture: got intr=%b cause=%b addr=%0h expected 1/01/1234",
                     ErrIntr, ErrCause, ErrAddr);
        end
        pulseClear();
        #2;
        compareCount++;
        if (ErrIntr !== 1'b0 || ErrCause !== 2'b00 || ErrAddr !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL unmapped_clear: got intr=%b cause=%b addr=%0h expected 0/00/0",
                     ErrIntr, ErrCause, ErrAddr);
        end
    endtask

    task automatic test_idle_unmapped();
        idleBus();
        applyStimulus('0, TR_IDLE, 34'h5555);
        step();
        applyStimulus('0, TR_BUSY, 34'h6666);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10 || HRDATA !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL idle_resp: got rdy/resp=%b data=%0h expected 10 0",
                     {HREADY, HRESP}, HRDATA);
        end
        step();
        applyStimulus('0, TR_IDLE, '0);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL busy_resp: got %b expected 10", {HREADY, HRESP});
        end
        step();
        #2;
        compareCount++;
        if (ErrIntr !== 1'b0 || ErrCause !== 2'b00) begin
            mismatchCount++;
            $display("[TB] FAIL idle_no_error: got intr=%b cause=%b expected 0 00", ErrIntr, ErrCause);
        end
    endtask

    task automatic test_timeout();
        idleBus();
        pulseClear();
        applyStimulus(4'b0010, TR_NONSEQ, 34'hABC0);
        step();
        applyStimulus('0, TR_IDLE, '0);
        setSub(1, 32'h0BAD_0BAD, 1'b0, 1'b0);
        repeat (MAX_STALL - 1) step();
        #2;
        compareCount++;
        if (ErrIntr !== 1'b0 || HREADY !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_early: got intr=%b rdy=%b expected 0 0", ErrIntr, HREADY);
        end
        step();
        #2;
        compareCount++;
        if (ErrIntr !== 1'b1 || ErrCause !== 2'b10 || ErrAddr !== 34'hABC0) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_flag: got intr=%b cause=%b addr=%0h expected 1/10/abc0",
                     ErrIntr, ErrCause, ErrAddr);
        end
        compareCount++;
        if ({HREADY, HRESP} !== 2'b00) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_bus_stalled: got %b expected 00", {HREADY, HRESP});
        end
        setSub(1, 32'h0BAD_0BAD, 1'b1, 1'b0);
        #2;
        compareCount++;
        if (HREADY !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_release: got %b expected 1", HREADY);
        end
        step();

        // Timeout after an earlier unmapped error must keep the first address.
        idleBus();
        pulseClear();
        applyStimulus('0, TR_NONSEQ, 34'h1234);
        step();
        applyStimulus(4'b0010, TR_NONSEQ, 34'h7770);
        step();
        step();
        applyStimulus('0, TR_IDLE, '0);
        setSub(1, 32'h1357_9BDF, 1'b0, 1'b0);
        repeat (MAX_STALL) step();
        #2;
        compareCount++;
        if (ErrIntr !== 1'b1 || ErrCause !== 2'b11 || ErrAddr !== 34'h1234 || HREADY !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL timeout_keeps_addr: got intr=%b cause=%b addr=%0h rdy=%b expected 1/11/1234/0",
                     ErrIntr, ErrCause, ErrAddr, HREADY);
        end
        setSub(1, 32'h1357_9BDF, 1'b1, 1'b0);
        step();
        idleBus();
        step();
    endtask

    task automatic test_back_to_back();
        idleBus();
        pulseClear();
        applyStimulus('0, TR_NONSEQ, 34'h100);
        step();
        applyStimulus('0, TR_NONSEQ, 34'h200);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b01) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_first_err1: got %b expected 01", {HREADY, HRESP});
        end
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b11) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_first_err2: got %b expected 11", {HREADY, HRESP});
        end
        step();
        applyStimulus('0, TR_IDLE, '0);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b01) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_second_err1: got %b expected 01", {HREADY, HRESP});
        end
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b11) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_second_err2: got %b expected 11", {HREADY, HRESP});
        end
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10 || ErrAddr !== 34'h100 || ErrCause !== 2'b01) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_end: got rdy/resp=%b addr=%0h cause=%b expected 10 100 01",
                     {HREADY, HRESP}, ErrAddr, ErrCause);
        end
    endtask

    task automatic test_reset_during_err();
        idleBus();
        pulseClear();
        applyStimulus('0, TR_NONSEQ, 34'h3000);
        step();
        applyStimulus('0, TR_IDLE, '0);
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b01 || ErrIntr !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL rst_err_setup: got rdy/resp=%b intr=%b expected 01 1",
                     {HREADY, HRESP}, ErrIntr);
        end
        reset = 1'b1;
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10 || ErrIntr !== 1'b0 || HSELD !== '0) begin
            mismatchCount++;
            $display("[TB] FAIL rst_err_abort: got rdy/resp=%b intr=%b hseld=%b expected 10 0 0000",
                     {HREADY, HRESP}, ErrIntr, HSELD);
        end
        reset = 1'b0;
        step();
        #2;
        compareCount++;
        if ({HREADY, HRESP} !== 2'b10) begin
            mismatchCount++;
            $display("[TB] FAIL rst_err_after: got %b expected 10", {HREADY, HRESP});
        end
    endtask

    task automatic test_clear_collision();
        idleBus();
        pulseClear();
        applyStimulus('0, TR_NONSEQ, 34'h1111);
        step();
        applyStimulus('0, TR_IDLE, '0);
        step();
        step();
        applyStimulus('0, TR_NONSEQ, 34'h2222);
        ErrClear = 1'b1;
        step();
        ErrClear = 1'b0;
        applyStimulus('0, TR_IDLE, '0);
        #2;
        compareCount++;
        if (ErrIntr !== 1'b1 || ErrCause !== 2'b01 || ErrAddr !== 34'h2222) begin
            mismatchCount++;
            $display("[TB] FAIL clear_collision: got intr=%b cause=%b addr=%0h expected 1/01/2222",
                     ErrIntr, ErrCause, ErrAddr);
        end
        step();
        step();
    endtask

    // Randomized traffic against a transaction-level model: the model keeps
    // the owner of the current data phase, how far an ERROR response has got,
    // how long the owner has stalled, and the sticky error record.
    task automatic test_random();
        int            dpKind;
        int            dpIdx;
        int            errPhase;
        int            stallCount;
        logic          mIntr;
        logic [1:0]    mCause;
        logic [AW-1:0] mAddr;
        logic [AW-1:0] dpAddr;
        logic [NS-1:0] sel;
        logic [1:0]    trans;
        logic [AW-1:0] addr;
        logic          clr;
        logic [DW-1:0] subData [NS];
        logic          subRdy [NS];
        logic          subResp [NS];
        logic [DW-1:0] expData;
        logic          expReady;
        logic          expResp;
        logic [NS-1:0] expSeld;
        logic          newUnm;
        logic          newTo;

        idleBus();
        step();
        step();
        pulseClear();
        step();
        dpKind     = 0;
        dpIdx      = 0;
        errPhase   = 0;
        stallCount = 0;
        mIntr      = 1'b0;
        mCause     = 2'b00;
        mAddr      = '0;
        dpAddr     = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            sel = '0;
            if ($urandom_range(0, 2) != 0) sel[$urandom_range(0, NS - 1)] = 1'b1;
            trans = 2'($urandom_range(0, 3));
            addr  = {2'($urandom_range(0, 3)), 32'($urandom)};
            clr   = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NS; i++) begin
                subData[i] = 32'($urandom);
                subRdy[i]  = ($urandom_range(0, 3) != 0);
                subResp[i] = ($urandom_range(0, 4) == 0);
                setSub(i, subData[i], subRdy[i], subResp[i]);
            end
            applyStimulus(sel, trans, addr);
            ErrClear = clr;
            #2;

            expData = '0;
            expSeld = '0;
            if (dpKind == 1) begin
                expData  = subData[dpIdx];
                expReady = subRdy[dpIdx];
                expResp  = subResp[dpIdx];
                expSeld[dpIdx] = 1'b1;
            end else if (dpKind == 2) begin
                expReady = (errPhase == 1);
                expResp  = 1'b1;
            end else begin
                expReady = 1'b1;
                expResp  = 1'b0;
            end

            compareCount++;
            if (HRDATA !== expData || {HREADY, HRESP} !== {expReady, expResp}) begin
                mismatchCount++;
                $display("[TB] FAIL rand_resp cyc %0d: got data=%0h rdy/resp=%b expected %0h %b",
                         cyc, HRDATA, {HREADY, HRESP}, expData, {expReady, expResp});
            end
            compareCount++;
            if (HSELD !== expSeld) begin
                mismatchCount++;
                $display("[TB] FAIL rand_hseld cyc %0d: got %b expected %b", cyc, HSELD, expSeld);
            end
            compareCount++;
            if ({ErrIntr, ErrCause} !== {mIntr, mCause} || ErrAddr !== mAddr) begin
                mismatchCount++;
                $display("[TB] FAIL rand_err cyc %0d: got %b/%b/%0h expected %b/%b/%0h",
                         cyc, ErrIntr, ErrCause, ErrAddr, mIntr, mCause, mAddr);
            end

            newUnm = expReady && (sel == '0) && trans[1];
            newTo  = 1'b0;
            if (expReady) begin
                stallCount = 0;
            end else if (dpKind == 1 && stallCount < MAX_STALL) begin
                stallCount++;
                if (stallCount == MAX_STALL) newTo = 1'b1;
            end
            if (clr) begin
                mIntr  = 1'b0;
                mCause = 2'b00;
                mAddr  = '0;
            end
            if (newUnm) begin
                if (!mIntr) mAddr = addr;
                mIntr     = 1'b1;
                mCause[0] = 1'b1;
            end
            if (newTo) begin
                if (!mIntr) mAddr = dpAddr;
                mIntr     = 1'b1;
                mCause[1] = 1'b1;
            end
            if (dpKind == 2 && errPhase == 0) begin
                errPhase = 1;
            end else if (expReady) begin
                if (sel == '0) begin
                    dpKind   = trans[1] ? 2 : 0;
                    errPhase = 0;
                end else begin
                    dpKind = 1;
                    for (int i = 0; i < NS; i++) if (sel[i]) dpIdx = i;
                end
                dpAddr = addr;
            end
            step();
        end
        idleBus();
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mapped_read();
        test_unmapped_error();
        test_idle_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_during_err();
        test_clear_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
